// File: rtl/pulse_id_scheduler.sv
// Round-robin arbiter sharing one pulse_identifier between several
// BMC decoder channels, with result handshake and stuck-pair watchdog.
module pulse_id_scheduler #(
   parameter int NUM_SENSORS   = 4,
   parameter int TIMEOUT_TICKS = 200000,
   localparam int SW = $clog2(NUM_SENSORS),
   localparam int TW = $clog2(TIMEOUT_TICKS + 1)
) (
   input  logic                      clk_96MHz,
   input  logic                      reset,
   input  logic [NUM_SENSORS-1:0]    data_availible,
   input  logic [NUM_SENSORS*24-1:0] ts_data,
   input  logic [NUM_SENSORS*17-1:0] decoded_data,
   output logic [NUM_SENSORS-1:0]    reset_bmc_decoder,
   output logic                      id_data_availible,
   output logic                      id_data_availible1,
   output logic [23:0]               id_ts_data,
   output logic [23:0]               id_ts_data_1,
   output logic [16:0]               id_decoded_data,
   output logic [16:0]               id_decoded_data_1,
   input  logic                      id_reset_bmc_0,
   input  logic                      id_reset_bmc_1,
   input  logic [16:0]               id_pulse_id_0,
   input  logic [16:0]               id_pulse_id_1,
   input  logic                      id_ready,
   output logic                      id_reset,
   output logic                      result_valid,
   input  logic                      result_ack,
   output logic [SW-1:0]             result_sensor_a,
   output logic [SW-1:0]             result_sensor_b,
   output logic [16:0]               result_pulse_id_a,
   output logic [16:0]               result_pulse_id_b,
   output logic [7:0]                timeout_count
);

   typedef enum logic [2:0] {
      IDLE, SELECT, RUN, HOLD, RELEASE, DRAIN
   } state_t;

   state_t        state;
   logic [SW-1:0] rr_ptr;
   logic [SW-1:0] sel_a;
   logic [SW-1:0] sel_b;
   logic [TW-1:0] timer;

   logic [SW-1:0] scan_a;
   logic [SW-1:0] scan_b;
   logic [SW-1:0] idx;
   logic          found_a;
   logic          found_b;
   logic          run;

   assign run = (state == RUN);

   // Circular scan: first pending channel from rr_ptr, then the next one after it
   always_comb begin
      idx     = '0;
      scan_a  = rr_ptr;
      found_a = 1'b0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
         idx = rr_ptr + SW'(i);
         if (!found_a && data_availible[idx]) begin
            scan_a  = idx;
            found_a = 1'b1;
         end
      end
      scan_b  = scan_a + SW'(1);
      found_b = 1'b0;
      for (int i = 1; i < NUM_SENSORS; i++) begin
         idx = scan_a + SW'(i);
         if (!found_b && data_availible[idx]) begin
            scan_b  = idx;
            found_b = 1'b1;
         end
      end
   end

   // Forward only the selected pair, and only while the identifier is running
   always_comb begin
      id_data_availible  = 1'b0;
      id_data_availible1 = 1'b0;
      id_ts_data         = '0;
      id_ts_data_1       = '0;
      id_decoded_data    = '0;
      id_decoded_data_1  = '0;
      reset_bmc_decoder  = '0;
      for (int k = 0; k < NUM_SENSORS; k++) begin
         if (run && sel_a == SW'(k)) begin
            id_data_availible    = data_availible[k];
            id_ts_data           = ts_data[24*k +: 24];
            id_decoded_data      = decoded_data[17*k +: 17];
            reset_bmc_decoder[k] = reset_bmc_decoder[k] | id_reset_bmc_0;
         end
         if (run && sel_b == SW'(k)) begin
            id_data_availible1   = data_availible[k];
            id_ts_data_1         = ts_data[24*k +: 24];
            id_decoded_data_1    = decoded_data[17*k +: 17];
            reset_bmc_decoder[k] = reset_bmc_decoder[k] | id_reset_bmc_1;
         end
      end
   end

   // Scheduler FSM with registered handshake, reset pulse and watchdog
   always_ff @(posedge clk_96MHz) begin
      if (reset) begin
         state             <= IDLE;
         rr_ptr            <= '0;
         sel_a             <= '0;
         sel_b             <= SW'(1);
         timer             <= '0;
         id_reset          <= 1'b0;
         result_valid      <= 1'b0;
         result_sensor_a   <= '0;
         result_sensor_b   <= '0;
         result_pulse_id_a <= '0;
         result_pulse_id_b <= '0;
         timeout_count     <= '0;
      end else begin
         id_reset <= 1'b0;
         unique case (state)
            IDLE: begin
               if (|data_availible) state <= SELECT;
            end
            SELECT: begin
               sel_a <= scan_a;
               sel_b <= scan_b;
               timer <= '0;
               state <= RUN;
            end
            RUN: begin
               timer <= timer + TW'(1);
               if (id_ready) begin
                  result_sensor_a   <= sel_a;
                  result_sensor_b   <= sel_b;
                  result_pulse_id_a <= id_pulse_id_0;
                  result_pulse_id_b <= id_pulse_id_1;
                  result_valid      <= 1'b1;
                  state             <= HOLD;
               end else if (timer == TW'(TIMEOUT_TICKS - 1)) begin
                  if (timeout_count != 8'hFF)
                     timeout_count <= timeout_count + 8'd1;
                  id_reset <= 1'b1;
                  state    <= RELEASE;
               end
            end
            HOLD: begin
               if (result_ack) begin
                  result_valid <= 1'b0;
                  id_reset     <= 1'b1;
                  state        <= RELEASE;
               end
            end
            RELEASE: begin
               rr_ptr <= sel_a + SW'(1);
               state  <= DRAIN;
            end
            DRAIN: begin
               if (!id_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_id_scheduler.sv
// Directed bench for pulse_id_scheduler with a result scoreboard
// and a hand-driven identifier model.
module tb_pulse_id_scheduler;

   localparam int N  = 4;
   localparam int T  = 40;
   localparam int SW = 2;

   logic            clk_96MHz = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    data_availible = '0;
   logic [N*24-1:0] ts_data = '0;
   logic [N*17-1:0] decoded_data = '0;
   logic [N-1:0]    reset_bmc_decoder;
   logic            id_data_availible;
   logic            id_data_availible1;
   logic [23:0]     id_ts_data;
   logic [23:0]     id_ts_data_1;
   logic [16:0]     id_decoded_data;
   logic [16:0]     id_decoded_data_1;
   logic            id_reset_bmc_0 = 1'b0;
   logic            id_reset_bmc_1 = 1'b0;
   logic [16:0]     id_pulse_id_0 = '0;
   logic [16:0]     id_pulse_id_1 = '0;
   logic            id_ready = 1'b0;
   logic            id_reset;
   logic            result_valid;
   logic            result_ack = 1'b0;
   logic [SW-1:0]   result_sensor_a;
   logic [SW-1:0]   result_sensor_b;
   logic [16:0]     result_pulse_id_a;
   logic [16:0]     result_pulse_id_b;
   logic [7:0]      timeout_count;

   pulse_id_scheduler #(
      .NUM_SENSORS(N),
      .TIMEOUT_TICKS(T)
   ) dut (
      .clk_96MHz(clk_96MHz),
      .reset(reset),
      .data_availible(data_availible),
      .ts_data(ts_data),
      .decoded_data(decoded_data),
      .reset_bmc_decoder(reset_bmc_decoder),
      .id_data_availible(id_data_availible),
      .id_data_availible1(id_data_availible1),
      .id_ts_data(id_ts_data),
      .id_ts_data_1(id_ts_data_1),
      .id_decoded_data(id_decoded_data),
      .id_decoded_data_1(id_decoded_data_1),
      .id_reset_bmc_0(id_reset_bmc_0),
      .id_reset_bmc_1(id_reset_bmc_1),
      .id_pulse_id_0(id_pulse_id_0),
      .id_pulse_id_1(id_pulse_id_1),
      .id_ready(id_ready),
      .id_reset(id_reset),
      .result_valid(result_valid),
      .result_ack(result_ack),
      .result_sensor_a(result_sensor_a),
      .result_sensor_b(result_sensor_b),
      .result_pulse_id_a(result_pulse_id_a),
      .result_pulse_id_b(result_pulse_id_b),
      .timeout_count(timeout_count)
   );

   always #5 clk_96MHz = ~clk_96MHz;

   typedef struct packed {
      logic [SW-1:0] sa;
      logic [SW-1:0] sb;
      logic [16:0]   pa;
      logic [16:0]   pb;
   } res_t;

   res_t sb_q[$];
   int   tests = 0;
   int   fails = 0;

   function automatic logic [23:0] exp_ts(input int k);
      return 24'h0A0000 + 24'(k * 273);
   endfunction

   function automatic logic [16:0] exp_dec(input int k);
      return 17'h0B000 + 17'(k);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_96MHz);
      #1;
   endtask

   task automatic wait_run(input string tag);
      int n = 0;
      while (id_data_availible !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_run"}, 64'(id_data_availible), 64'(1));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rv"}, 64'(result_valid), 64'(0));
      chk({tag, "_idrst"}, 64'(id_reset), 64'(0));
      chk({tag, "_tocnt"}, 64'(timeout_count), 64'(0));
      chk({tag, "_dav"},
          64'({id_data_availible, id_data_availible1}), 64'(0));
      chk({tag, "_bmc"}, 64'(reset_bmc_decoder), 64'(0));
      chk({tag, "_ts"}, 64'({id_ts_data, id_ts_data_1}), 64'(0));
      chk({tag, "_res"},
          64'({result_sensor_a, result_sensor_b,
               result_pulse_id_a, result_pulse_id_b}), 64'(0));
   endtask

   task automatic round(input logic [SW-1:0] ea, input logic [SW-1:0] eb,
                        input logic [16:0] pa, input logic [16:0] pb,
                        input int hold, input logic [N-1:0] da_after,
                        input string tag);
      res_t       e;
      res_t       got;
      logic [3:0] m;
      wait_run(tag);
      chk({tag, "_ts_a"}, 64'(id_ts_data), 64'(exp_ts(int'(ea))));
      chk({tag, "_ts_b"}, 64'(id_ts_data_1), 64'(exp_ts(int'(eb))));
      chk({tag, "_dec_a"}, 64'(id_decoded_data), 64'(exp_dec(int'(ea))));
      chk({tag, "_dec_b"}, 64'(id_decoded_data_1), 64'(exp_dec(int'(eb))));
      id_reset_bmc_0 = 1'b1;
      #1;
      m = 4'b0001 << ea;
      chk({tag, "_bmc0"}, 64'(reset_bmc_decoder), 64'(m));
      id_reset_bmc_0 = 1'b0;
      id_reset_bmc_1 = 1'b1;
      #1;
      m = 4'b0001 << eb;
      chk({tag, "_bmc1"}, 64'(reset_bmc_decoder), 64'(m));
      id_reset_bmc_1 = 1'b0;
      e.sa = ea;
      e.sb = eb;
      e.pa = pa;
      e.pb = pb;
      sb_q.push_back(e);
      id_pulse_id_0 = pa;
      id_pulse_id_1 = pb;
      id_ready = 1'b1;
      step();
      id_ready = 1'b0;
      data_availible = da_after;
      chk({tag, "_hold_dav"}, 64'(id_data_availible), 64'(0));
      chk({tag, "_valid"}, 64'(result_valid), 64'(1));
      chk({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'(1));
      got = '0;
      if (sb_q.size() > 0) begin
         got = sb_q.pop_front();
         chk({tag, "_result"},
             64'({result_sensor_a, result_sensor_b,
                  result_pulse_id_a, result_pulse_id_b}), 64'(got));
      end
      for (int i = 0; i < hold; i++) begin
         step();
         chk({tag, "_stable"},
             64'({result_valid, id_reset, result_sensor_a, result_sensor_b,
                  result_pulse_id_a, result_pulse_id_b}),
             64'({1'b1, 1'b0, got}));
      end
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      chk({tag, "_rel_idrst"}, 64'(id_reset), 64'(1));
      chk({tag, "_rel_valid"}, 64'(result_valid), 64'(0));
      step();
      chk({tag, "_drain_idrst"}, 64'(id_reset), 64'(0));
      step();
      chk({tag, "_keep"},
          64'({result_sensor_a, result_sensor_b,
               result_pulse_id_a, result_pulse_id_b}), 64'(got));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int  n;
      bit  rv_seen;
      for (int k = 0; k < N; k++) begin
         ts_data[24*k +: 24]      = exp_ts(k);
         decoded_data[17*k +: 17] = exp_dec(k);
      end
      step();
      step();
      reset = 1'b0;
      chk_zero("por");

      // ch1 pending, ch2 arrives later while the pair is running
      data_availible = 4'b0010;
      wait_run("t1a");
      chk("t1_sel_b_dav", 64'(id_data_availible1), 64'(0));
      chk("t1_sel_b_ts", 64'(id_ts_data_1), 64'(exp_ts(2)));
      for (int i = 0; i < 10; i++) step();
      data_availible = 4'b0110;
      #1;
      chk("t1_sel_b_late", 64'(id_data_availible1), 64'(1));
      round(2'd1, 2'd2, 17'h00123, 17'h00456, 0, 4'b0000, "t1");

      // rr_ptr now 2: with ch0/ch3 pending the pair must be (3,0)
      data_availible = 4'b1001;
      wait_run("t1_rr");
      chk("t1_rr_a", 64'(id_ts_data), 64'(exp_ts(3)));
      chk("t1_rr_b", 64'(id_ts_data_1), 64'(exp_ts(0)));
      reset = 1'b1;
      data_availible = 4'b0000;
      step();
      reset = 1'b0;
      chk_zero("t5_run");

      // all channels busy: pairs rotate without starvation
      data_availible = 4'b1111;
      round(2'd0, 2'd1, 17'h00011, 17'h00022, 0, 4'b1111, "t2r0");
      round(2'd1, 2'd2, 17'h00033, 17'h00044, 0, 4'b1111, "t2r1");
      round(2'd2, 2'd3, 17'h00055, 17'h00066, 0, 4'b0000, "t2r2");
      reset = 1'b1;
      step();
      reset = 1'b0;

      // lone ch3, identifier never answers
      data_availible = 4'b1000;
      wait_run("t3");
      chk("t3_a", 64'(id_ts_data), 64'(exp_ts(3)));
      chk("t3_b", 64'(id_ts_data_1), 64'(exp_ts(0)));
      n = 0;
      rv_seen = 1'b0;
      while (id_data_availible === 1'b1 && n < T + 5) begin
         if (result_valid) rv_seen = 1'b1;
         n++;
         step();
      end
      chk("t3_run_cycles", 64'(n), 64'(T));
      chk("t3_idrst", 64'(id_reset), 64'(1));
      chk("t3_tocnt", 64'(timeout_count), 64'(1));
      chk("t3_no_result", 64'({rv_seen, result_valid}), 64'(0));
      data_availible = 4'b0000;
      step();
      chk("t3_idrst_once", 64'(id_reset), 64'(0));
      step();

      // slow consumer: result held 500 cycles
      data_availible = 4'b0011;
      round(2'd0, 2'd1, 17'h1ABCD, 17'h0BEEF, 500, 4'b0000, "t4");
      chk("t4_tocnt", 64'(timeout_count), 64'(1));

      // reset while a result is held
      data_availible = 4'b0011;
      wait_run("t5h");
      id_pulse_id_0 = 17'h00777;
      id_pulse_id_1 = 17'h00888;
      id_ready = 1'b1;
      step();
      id_ready = 1'b0;
      chk("t5h_valid", 64'(result_valid), 64'(1));
      reset = 1'b1;
      data_availible = 4'b0000;
      step();
      reset = 1'b0;
      chk_zero("t5_hold");
      step();
      step();
      chk_zero("t5_idle");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
